// File: rtl/fft_r4_input_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_r4_input_buffer_if
// Purpose  : Sample-in / radix-4 group-out handshake bundle for the FFT input buffer.
// Revision : 1.0  initial release
// ============================================================================
interface fft_r4_input_buffer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_real;
    logic [DATA_W-1:0] in_im;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_real_0;
    logic [DATA_W-1:0] out_real_1;
    logic [DATA_W-1:0] out_real_2;
    logic [DATA_W-1:0] out_real_3;
    logic [DATA_W-1:0] out_im_0;
    logic [DATA_W-1:0] out_im_1;
    logic [DATA_W-1:0] out_im_2;
    logic [DATA_W-1:0] out_im_3;
    logic              out_first;
    logic              out_last;

    modport master (
        output in_valid, in_real, in_im, out_ready,
        input  in_ready, out_valid,
        input  out_real_0, out_real_1, out_real_2, out_real_3,
        input  out_im_0, out_im_1, out_im_2, out_im_3,
        input  out_first, out_last
    );

    modport slave (
        input  in_valid, in_real, in_im, out_ready,
        output in_ready, out_valid,
        output out_real_0, out_real_1, out_real_2, out_real_3,
        output out_im_0, out_im_1, out_im_2, out_im_3,
        output out_first, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fft_r4_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_r4_input_buffer
// Purpose  : Ping-pong frame buffer that reorders natural-order samples into
//            radix-4 DIF operand groups x[k], x[k+N/4], x[k+N/2], x[k+3N/4].
// Revision : 1.0  initial release
// ============================================================================
module fft_r4_input_buffer #(
    parameter int DATA_W   = 32,
    parameter int N_POINTS = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              flush,
    fft_r4_input_buffer_if.slave   bus
);

    localparam int c_AW = $clog2(N_POINTS);
    localparam int c_QW = c_AW - 2;
    localparam int c_EW = 2 * DATA_W;

    localparam logic [c_AW-1:0] c_WR_LAST = c_AW'(N_POINTS - 1);
    localparam logic [c_QW-1:0] c_RD_LAST = c_QW'(N_POINTS / 4 - 1);
    localparam logic [c_AW-1:0] c_WR_ONE  = c_AW'(1);
    localparam logic [c_QW-1:0] c_RD_ONE  = c_QW'(1);

    generate
        if ((N_POINTS < 16) || ((N_POINTS & (N_POINTS - 1)) != 0) || ((c_AW % 2) != 0))
        begin : g_bad_n_points
            $error("fft_r4_input_buffer: N_POINTS must be a power of 4 and >= 16");
        end
    endgenerate

    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [c_AW-1:0]   r_wr_cnt;
    logic [c_QW-1:0]   r_rd_cnt;
    logic [1:0]        r_full;
    logic [c_EW-1:0]   r_mem [0:1][0:N_POINTS-1];

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_wr_done;
    logic              w_rd_done;
    logic [1:0]        w_full_nxt;
    logic [c_EW-1:0]   w_lane [4];

    assign w_in_ready  = ~r_full[r_wr_bank];
    assign w_out_valid = r_full[r_rd_bank];
    assign w_wr_fire   = bus.in_valid & w_in_ready;
    assign w_rd_fire   = w_out_valid & bus.out_ready;
    assign w_wr_done   = w_wr_fire & (r_wr_cnt == c_WR_LAST);
    assign w_rd_done   = w_rd_fire & (r_rd_cnt == c_RD_LAST);

    // A completing write and a completing read always hit opposite banks,
    // so both flag edits are applied to the same next-state vector.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= '0;
        end else if (flush) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_cnt <= w_wr_done ? '0 : (r_wr_cnt + c_WR_ONE);
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_rd_fire) begin
                r_rd_cnt <= w_rd_done ? '0 : (r_rd_cnt + c_RD_ONE);
                if (w_rd_done) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
            r_full <= w_full_nxt;
        end
    end

    // Sample storage; cleared only by reset so a flush leaves stale data behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < N_POINTS; a++) begin
                    r_mem[b][a] <= '0;
                end
            end
        end else if (!flush && w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_cnt] <= {bus.in_real, bus.in_im};
        end
    end

    // Lane j address is rd_cnt + j*N/4, i.e. j in the two top address bits.
    generate
        for (genvar j = 0; j < 4; j++) begin : g_lane
            localparam logic [1:0] c_LANE = 2'(j);
            assign w_lane[j] = r_mem[r_rd_bank][{c_LANE, r_rd_cnt}];
        end
    endgenerate

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_first  = w_out_valid & (r_rd_cnt == '0);
    assign bus.out_last   = w_out_valid & (r_rd_cnt == c_RD_LAST);

    assign bus.out_real_0 = w_lane[0][c_EW-1:DATA_W];
    assign bus.out_real_1 = w_lane[1][c_EW-1:DATA_W];
    assign bus.out_real_2 = w_lane[2][c_EW-1:DATA_W];
    assign bus.out_real_3 = w_lane[3][c_EW-1:DATA_W];
    assign bus.out_im_0   = w_lane[0][DATA_W-1:0];
    assign bus.out_im_1   = w_lane[1][DATA_W-1:0];
    assign bus.out_im_2   = w_lane[2][DATA_W-1:0];
    assign bus.out_im_3   = w_lane[3][DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fft_r4_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_r4_input_buffer
// Purpose  : Scoreboard bench for the radix-4 input buffer (N=16 and N=64).
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_r4_input_buffer;

    localparam int DW = 32;

    typedef struct packed {
        logic [3:0][DW-1:0] re;
        logic [3:0][DW-1:0] im;
        logic               first;
        logic               last;
    } grp_t;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic flush16 = 1'b0;
    logic flush64 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    grp_t        q16[$];
    logic [DW-1:0] fr_re [16];
    logic [DW-1:0] fr_im [16];
    int          wcnt16 = 0;

    always #5 clk = ~clk;

    fft_r4_input_buffer_if #(.DATA_W(DW)) bus16 ();
    fft_r4_input_buffer_if #(.DATA_W(DW)) bus64 ();

    fft_r4_input_buffer #(.DATA_W(DW), .N_POINTS(16)) dut16 (
        .clk(clk), .reset(reset), .flush(flush16), .bus(bus16));
    fft_r4_input_buffer #(.DATA_W(DW), .N_POINTS(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush64), .bus(bus64));

    function automatic logic [31:0] fbits(input int v);
        int e;
        e = 0;
        if (v == 0) return 32'h0;
        while ((v >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((v - (1 << e)) << (23 - e))};
    endfunction

    // Reference model: records accepted samples, pushes the expected groups on frame completion.
    always @(negedge clk) begin : mon16
        grp_t a;
        grp_t e;
        if (reset) begin
            if (flush16) begin
                q16.delete();
                wcnt16 = 0;
            end else begin
                if (bus16.out_valid && bus16.out_ready) begin
                    a.re    = {bus16.out_real_3, bus16.out_real_2, bus16.out_real_1, bus16.out_real_0};
                    a.im    = {bus16.out_im_3, bus16.out_im_2, bus16.out_im_1, bus16.out_im_0};
                    a.first = bus16.out_first;
                    a.last  = bus16.out_last;
                    n_checks++;
                    if (q16.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_unexpected: got %h, expected no group", a);
                    end else begin
                        e = q16.pop_front();
                        if (a !== e) begin
                            n_errors++;
                            $display("FAIL sb_group: got %h expected %h", a, e);
                        end
                    end
                end
                if (bus16.in_valid && bus16.in_ready) begin
                    fr_re[wcnt16] = bus16.in_real;
                    fr_im[wcnt16] = bus16.in_im;
                    wcnt16++;
                    if (wcnt16 == 16) begin
                        for (int k = 0; k < 4; k++) begin
                            for (int j = 0; j < 4; j++) begin
                                e.re[j] = fr_re[k + 4 * j];
                                e.im[j] = fr_im[k + 4 * j];
                            end
                            e.first = (k == 0);
                            e.last  = (k == 3);
                            q16.push_back(e);
                        end
                        wcnt16 = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time %0t, required finish before 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [DW-1:0] re, input logic [DW-1:0] im, output int waited);
        logic rdy;
        bus16.in_valid = 1'b1;
        bus16.in_real  = re;
        bus16.in_im    = im;
        waited = 0;
        do begin
            rdy = bus16.in_ready;
            step();
            waited++;
        end while (!rdy && waited < 200);
        bus16.in_valid = 1'b0;
    endtask

    task automatic drain16(output bit ok);
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (q16.size() == 0 && !bus16.out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bus16.in_valid = 0; bus16.in_real = 0; bus16.in_im = 0; bus16.out_ready = 0;
        bus64.in_valid = 0; bus64.in_real = 0; bus64.in_im = 0; bus64.out_ready = 0;
        reset = 1'b0;
        #2;
        n_checks++;
        if ({bus16.in_ready, bus16.out_valid, bus16.out_first, bus16.out_last} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_flags16: got %b expected 1000",
                     {bus16.in_ready, bus16.out_valid, bus16.out_first, bus16.out_last});
        end
        n_checks++;
        if ({bus16.out_real_0, bus16.out_real_1, bus16.out_real_2, bus16.out_real_3,
             bus16.out_im_0, bus16.out_im_1, bus16.out_im_2, bus16.out_im_3} !== '0) begin
            n_errors++;
            $display("FAIL reset_data16: got %h expected 0", {bus16.out_real_0, bus16.out_im_3});
        end
        n_checks++;
        if ({bus64.in_ready, bus64.out_valid, bus64.out_first, bus64.out_last} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_flags64: got %b expected 1000",
                     {bus64.in_ready, bus64.out_valid, bus64.out_first, bus64.out_last});
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_basic_order();
        int hi;
        bit ok;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus16.in_valid = 1'b1;
            bus16.in_real  = fbits(i);
            bus16.in_im    = fbits(i);
            n_checks++;
            if (bus16.in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL basic_in_ready: sample %0d got %b expected 1", i, bus16.in_ready);
            end
            step();
        end
        bus16.in_valid = 1'b0;
        hi = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus16.out_valid) hi++;
            if (c == 0) begin
                n_checks++;
                if ({bus16.out_real_0, bus16.out_real_1, bus16.out_real_2, bus16.out_real_3, bus16.out_first}
                    !== {32'h00000000, 32'h40800000, 32'h41000000, 32'h41400000, 1'b1}) begin
                    n_errors++;
                    $display("FAIL basic_group0: got %h %h %h %h first=%b expected 0 40800000 41000000 41400000 first=1",
                             bus16.out_real_0, bus16.out_real_1, bus16.out_real_2, bus16.out_real_3, bus16.out_first);
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({bus16.out_im_0, bus16.out_im_1, bus16.out_im_2, bus16.out_im_3, bus16.out_last}
                    !== {32'h40400000, 32'h40E00000, 32'h41300000, 32'h41700000, 1'b1}) begin
                    n_errors++;
                    $display("FAIL basic_group3: got %h %h %h %h last=%b expected 40400000 40e00000 41300000 41700000 last=1",
                             bus16.out_im_0, bus16.out_im_1, bus16.out_im_2, bus16.out_im_3, bus16.out_last);
                end
            end
            step();
        end
        n_checks++;
        if (hi != 4) begin
            n_errors++;
            $display("FAIL basic_valid_cycles: got %0d expected 4", hi);
        end
        drain16(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL basic_drain: pending %0d expected 0", q16.size());
        end
    endtask

    task automatic test_back_pressure();
        int w;
        int slow;
        bit ok;
        bus16.out_ready = 1'b0;
        slow = 0;
        for (int i = 0; i < 32; i++) begin
            send16(32'h1000 + 32'(i), 32'h2000 + 32'(i), w);
            if (w != 1) slow++;
        end
        n_checks++;
        if (slow != 0 || bus16.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_fill: stalls=%0d in_ready=%b expected stalls=0 in_ready=0", slow, bus16.in_ready);
        end
        bus16.in_valid = 1'b1;
        bus16.in_real  = 32'h1000 + 32'd32;
        bus16.in_im    = 32'h2000 + 32'd32;
        for (int h = 0; h < 3; h++) begin
            n_checks++;
            if ({bus16.in_ready, bus16.out_first, bus16.out_real_0, bus16.out_real_1, bus16.out_real_2, bus16.out_im_3}
                !== {1'b0, 1'b1, 32'h1000, 32'h1004, 32'h1008, 32'h200C}) begin
                n_errors++;
                $display("FAIL bp_frozen: got rdy=%b first=%b %h %h %h %h expected rdy=0 first=1 1000 1004 1008 200c",
                         bus16.in_ready, bus16.out_first, bus16.out_real_0, bus16.out_real_1,
                         bus16.out_real_2, bus16.out_im_3);
            end
            step();
        end
        bus16.out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            step();
            n_checks++;
            if (bus16.in_ready !== (r == 3)) begin
                n_errors++;
                $display("FAIL bp_release: read %0d in_ready=%b expected %b", r + 1, bus16.in_ready, (r == 3));
            end
        end
        step();
        bus16.in_valid = 1'b0;
        for (int i = 33; i < 48; i++) send16(32'h1000 + 32'(i), 32'h2000 + 32'(i), w);
        drain16(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL bp_drain: pending %0d expected 0", q16.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int c = 1; c <= 56; c++) begin
            bus16.in_valid  = (c <= 48);
            bus16.in_real   = fbits(c - 1);
            bus16.in_im     = fbits(c - 1);
            bus16.out_ready = (c >= 29);
            if (c <= 48) begin
                n_checks++;
                if (bus16.in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", c, bus16.in_ready);
                end
            end
            step();
            if (c >= 16 && c <= 35) begin
                n_checks++;
                if (bus16.out_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_out_valid: edge %0d got %b expected 1", c, bus16.out_valid);
                end
            end
            if (c == 32) begin
                n_checks++;
                if ({bus16.out_first, bus16.out_real_0, bus16.out_real_1, bus16.out_real_2, bus16.out_real_3}
                    !== {1'b1, 32'h41800000, 32'h41A00000, 32'h41C00000, 32'h41E00000}) begin
                    n_errors++;
                    $display("FAIL b2b_frame2_g0: got first=%b %h %h %h %h expected first=1 41800000 41a00000 41c00000 41e00000",
                             bus16.out_first, bus16.out_real_0, bus16.out_real_1, bus16.out_real_2, bus16.out_real_3);
                end
            end
            if (c == 36) begin
                n_checks++;
                if (bus16.out_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_gap: edge 36 out_valid=%b expected 0", bus16.out_valid);
                end
            end
        end
        drain16(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL b2b_drain: pending %0d expected 0", q16.size());
        end
    endtask

    task automatic test_random_gaps();
        int i, cyc, n_first, n_last;
        logic rdy;
        logic [DW-1:0] cur_re, cur_im;
        i = 0; cyc = 0; n_first = 0; n_last = 0;
        cur_re = $urandom; cur_im = $urandom;
        while ((i < 160 || q16.size() != 0) && cyc < 6000) begin
            bus16.in_valid  = (i < 160) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus16.in_real   = cur_re;
            bus16.in_im     = cur_im;
            bus16.out_ready = (i < 160) ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy = bus16.in_ready;
            if (bus16.out_valid && bus16.out_ready) begin
                if (bus16.out_first) n_first++;
                if (bus16.out_last)  n_last++;
            end
            step();
            if (bus16.in_valid && rdy) begin
                i++;
                cur_re = $urandom;
                cur_im = $urandom;
            end
            cyc++;
        end
        bus16.in_valid = 1'b0;
        n_checks++;
        if (cyc >= 6000) begin
            n_errors++;
            $display("FAIL rand_timeout: accepted %0d pending %0d expected 160 and 0", i, q16.size());
        end
        n_checks++;
        if (n_first != 10 || n_last != 10) begin
            n_errors++;
            $display("FAIL rand_first_last: got first=%0d last=%0d expected 10 10", n_first, n_last);
        end
    endtask

    task automatic test_flush();
        int w;
        bit ok;
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 23; i++) send16(32'h3000 + 32'(i), 32'h3100 + 32'(i), w);
        flush16 = 1'b1;
        bus16.in_valid  = 1'b1;
        bus16.in_real   = 32'hDEAD;
        bus16.out_ready = 1'b1;
        step();
        flush16 = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        n_checks++;
        if ({bus16.in_ready, bus16.out_valid, bus16.out_first} !== 3'b100) begin
            n_errors++;
            $display("FAIL flush_state: got rdy=%b valid=%b first=%b expected 1 0 0",
                     bus16.in_ready, bus16.out_valid, bus16.out_first);
        end
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send16(32'h4000 + 32'(i), 32'h4100 + 32'(i), w);
        drain16(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL flush_drain: pending %0d expected 0", q16.size());
        end
    endtask

    task automatic test_async_reset();
        int w;
        bit ok;
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send16(32'h5000 + 32'(i), 32'h5100 + 32'(i), w);
        n_checks++;
        if (bus16.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL arst_pre: out_valid=%b expected 1", bus16.out_valid);
        end
        #2;
        reset = 1'b0;
        q16.delete();
        wcnt16 = 0;
        #1;
        n_checks++;
        if ({bus16.in_ready, bus16.out_valid, bus16.out_first, bus16.out_last,
             bus16.out_real_0, bus16.out_real_1, bus16.out_real_2, bus16.out_real_3,
             bus16.out_im_0, bus16.out_im_1, bus16.out_im_2, bus16.out_im_3} !== {4'b1000, 256'h0}) begin
            n_errors++;
            $display("FAIL arst_outputs: got rdy=%b valid=%b first=%b last=%b re0=%h im3=%h expected 1 0 0 0 0 0",
                     bus16.in_ready, bus16.out_valid, bus16.out_first, bus16.out_last,
                     bus16.out_real_0, bus16.out_im_3);
        end
        step();
        reset = 1'b1;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send16(32'h6000 + 32'(i), 32'h6100 + 32'(i), w);
        drain16(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL arst_drain: pending %0d expected 0", q16.size());
        end
    endtask

    task automatic test_n64();
        logic [257:0] act, exp_g;
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus64.in_valid = 1'b1;
            bus64.in_real  = 32'(i);
            bus64.in_im    = 32'(i + 256);
            n_checks++;
            if (bus64.in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL n64_in_ready: sample %0d got %b expected 1", i, bus64.in_ready);
            end
            step();
        end
        bus64.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            act = {bus64.out_real_0, bus64.out_real_1, bus64.out_real_2, bus64.out_real_3,
                   bus64.out_im_0, bus64.out_im_1, bus64.out_im_2, bus64.out_im_3,
                   bus64.out_first, bus64.out_last};
            exp_g = {32'(k), 32'(k + 16), 32'(k + 32), 32'(k + 48),
                     32'(k + 256), 32'(k + 272), 32'(k + 288), 32'(k + 304),
                     (k == 0), (k == 15)};
            n_checks++;
            if (bus64.out_valid !== 1'b1 || act !== exp_g) begin
                n_errors++;
                $display("FAIL n64_group%0d: valid=%b got %h expected valid=1 %h", k, bus64.out_valid, act, exp_g);
            end
            step();
        end
        n_checks++;
        if (bus64.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL n64_end: out_valid=%b expected 0", bus64.out_valid);
        end
        bus64.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_back_pressure();
        test_back_to_back();
        test_random_gaps();
        test_flush();
        test_async_reset();
        test_n64();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
